// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry and clear-engine state encoding for the VGA
// video-RAM arbiter.
package vga_pkg;

   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned FB_PIXELS = 76800;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } clr_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding pending {addr, data} pixel writes until the
// arbiter finds a free RAM slot for them.
module vram_wr_fifo #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads own their slots, buffered
// client writes and the clear-screen engine share the remaining cycles.
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int unsigned ADDR_W     = vga_pkg::ADDR_W,
   parameter int unsigned DATA_W     = vga_pkg::DATA_W,
   parameter int unsigned FB_PIXELS  = vga_pkg::FB_PIXELS,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_pix_stb,
   input  logic              i_active,
   input  logic [ADDR_W-1:0] i_xy,
   output logic [DATA_W-1:0] o_pix_data,
   output logic              o_pix_valid,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_clear_req,
   input  logic [DATA_W-1:0] i_clear_colour,
   output logic              o_clear_busy,
   output logic              o_clear_done,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   localparam int unsigned       ENT_W     = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [DATA_W-1:0] colour_q, colour_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              done_q, done_d;
   logic              rd_pend_q;
   logic              pix_valid_q;
   logic [DATA_W-1:0] pix_data_q;

   logic              read_slot;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ENT_W-1:0]  fifo_head;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              head_in_frame;

   assign read_slot     = i_pix_stb & i_active;
   assign o_wr_ready    = ~fifo_full & (state_q == IDLE) & ~i_rst;
   assign fifo_push     = i_wr_valid & o_wr_ready;
   assign head_addr     = fifo_head[ENT_W-1:DATA_W];
   assign head_data     = fifo_head[DATA_W-1:0];
   assign head_in_frame = (32'(head_addr) < FB_PIXELS);

   vram_wr_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .push_i      (fifo_push),
      .push_data_i ({i_wr_addr, i_wr_data}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Clear FSM plus slot arbitration: read slot > clear engine > FIFO head.
   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      colour_d    = colour_q;
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      done_d      = 1'b0;
      fifo_pop    = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_clear_req) begin
               colour_d = i_clear_colour;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               clr_addr_d = '0;
               state_d    = CLEAR;
            end
         end
         CLEAR: begin
            if (!read_slot) begin
               if (clr_addr_q == LAST_ADDR) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  clr_addr_d = clr_addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (read_slot) begin
         ram_addr_d = i_xy;
      end else if (state_q == CLEAR) begin
         ram_addr_d  = clr_addr_q;
         ram_we_d    = 1'b1;
         ram_wdata_d = colour_q;
      end else if (!fifo_empty) begin
         // Off-frame entries are consumed without touching the RAM.
         fifo_pop = 1'b1;
         if (head_in_frame) begin
            ram_addr_d  = head_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = head_data;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         clr_addr_q  <= '0;
         colour_q    <= '0;
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         done_q      <= 1'b0;
         rd_pend_q   <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         colour_q    <= colour_d;
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         done_q      <= done_d;
         rd_pend_q   <= read_slot;
         pix_valid_q <= rd_pend_q;
         if (rd_pend_q) pix_data_q <= i_ram_rdata;
      end
   end

   assign o_ram_addr   = ram_addr_q;
   assign o_ram_we     = ram_we_q;
   assign o_ram_wdata  = ram_wdata_q;
   assign o_clear_done = done_q;
   assign o_clear_busy = (state_q != IDLE);
   assign o_pix_valid  = pix_valid_q;
   assign o_pix_data   = pix_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected reads and RAM writes are queued
// as stimulus is applied and retired against the DUT outputs.
module tb_vram_arbiter;
   import vga_pkg::*;

   localparam int unsigned AW = vga_pkg::ADDR_W;
   localparam int unsigned DW = vga_pkg::DATA_W;
   localparam int unsigned FB = vga_pkg::FB_PIXELS;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } rd_exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_stb, active;
   logic [AW-1:0] xy;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          clear_req;
   logic [DW-1:0] clear_colour;
   logic          clear_busy, clear_done;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int            n_vec = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            n_wr_seen = 0;
   int            n_clr_we = 0;
   int            n_done = 0;
   logic          track_wr = 1'b1;
   logic          prev_slot = 1'b0;
   rd_exp_t       rd_q[$];
   logic [AW+DW-1:0] wr_q[$];
   rd_exp_t       re;
   logic [AW+DW-1:0] we_e;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 8'h86;
   endfunction

   // Asynchronous-read RAM model: data follows the registered address.
   assign ram_rdata = pat(ram_addr);

   vram_arbiter dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_pix_stb      (pix_stb),
      .i_active       (active),
      .i_xy           (xy),
      .o_pix_data     (pix_data),
      .o_pix_valid    (pix_valid),
      .i_wr_valid     (wr_valid),
      .o_wr_ready     (wr_ready),
      .i_wr_addr      (wr_addr),
      .i_wr_data      (wr_data),
      .i_clear_req    (clear_req),
      .i_clear_colour (clear_colour),
      .o_clear_busy   (clear_busy),
      .o_clear_done   (clear_done),
      .o_ram_addr     (ram_addr),
      .o_ram_we       (ram_we),
      .o_ram_wdata    (ram_wdata),
      .i_ram_rdata    (ram_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Retire outputs first, then queue expectations for this cycle's stimulus.
   always @(negedge clk) begin
      cyc++;
      if (pix_valid) begin
         if (rd_q.size() == 0) begin
            check_eq("pix_unexpected", 32'(1), 32'(0));
         end else begin
            re = rd_q.pop_front();
            check_eq("pix_data", 32'(pix_data), 32'(re.data));
            check_eq("pix_latency", 32'(cyc - re.cyc), 32'(2));
         end
      end
      if (ram_we) begin
         if (!track_wr) begin
            n_clr_we++;
         end else if (wr_q.size() == 0) begin
            check_eq("wr_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
         end else begin
            we_e = wr_q.pop_front();
            n_wr_seen++;
            check_eq("wr_addr", 32'(ram_addr), 32'(we_e[AW+DW-1:DW]));
            check_eq("wr_data", 32'(ram_wdata), 32'(we_e[DW-1:0]));
            check_eq("wr_in_read_slot", 32'(prev_slot), 32'(0));
         end
      end
      if (clear_done) begin
         n_done++;
         check_eq("done_with_last", 32'({ram_we, ram_addr}), 32'({1'b1, AW'(FB - 1)}));
      end
      if (!rst && pix_stb && active) rd_q.push_back('{pat(xy), cyc});
      if (!rst && track_wr && wr_valid && wr_ready && (32'(wr_addr) < FB))
         wr_q.push_back({wr_addr, wr_data});
      prev_slot = pix_stb & active;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got hang expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int done0, we0, seen0;
      rst = 1'b1; pix_stb = 1'b0; active = 1'b0; xy = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      clear_req = 1'b0; clear_colour = '0;
      repeat (3) step();

      // Reset state
      check_eq("rst_pix_valid", 32'(pix_valid), 32'(0));
      check_eq("rst_pix_data", 32'(pix_data), 32'(0));
      check_eq("rst_ram_addr", 32'(ram_addr), 32'(0));
      check_eq("rst_ram_we", 32'(ram_we), 32'(0));
      check_eq("rst_ram_wdata", 32'(ram_wdata), 32'(0));
      check_eq("rst_busy", 32'(clear_busy), 32'(0));
      check_eq("rst_done", 32'(clear_done), 32'(0));
      check_eq("rst_wr_ready", 32'(wr_ready), 32'(0));
      rst = 1'b0;
      step();
      check_eq("post_rst_ready", 32'(wr_ready), 32'(1));

      // Single scanout read
      pix_stb = 1'b1; active = 1'b1; xy = AW'(17'h00123);
      step();
      pix_stb = 1'b0; active = 1'b0;
      check_eq("rd_ram_addr", 32'(ram_addr), 32'h123);
      check_eq("rd_ram_we", 32'(ram_we), 32'(0));
      step();
      check_eq("rd_pix_valid", 32'(pix_valid), 32'(1));
      check_eq("rd_pix_a5", 32'(pix_data), 32'hA5);
      repeat (3) step();

      // Write sharing active video with strobe every 2nd cycle
      seen0 = n_wr_seen;
      active = 1'b1;
      for (int i = 0; i < 24; i++) begin
         pix_stb  = (i % 2 == 0);
         xy       = AW'(32'h200 + 32'(i));
         wr_valid = (i == 3);
         wr_addr  = AW'(17'h00010);
         wr_data  = 8'h3C;
         step();
      end
      pix_stb = 1'b0; active = 1'b0; wr_valid = 1'b0;
      repeat (4) step();
      check_eq("free_slot_writes", 32'(n_wr_seen - seen0), 32'(1));

      // FIFO full: strobe every cycle leaves no free slot
      seen0 = n_wr_seen;
      pix_stb = 1'b1; active = 1'b1;
      for (int k = 0; k < 6; k++) begin
         xy       = AW'(32'h300 + 32'(k));
         wr_valid = 1'b1;
         wr_addr  = AW'(32'h100 + 32'(k));
         wr_data  = DW'(32'h50 + 32'(k));
         check_eq($sformatf("full_ready_%0d", k), 32'(wr_ready), 32'(k < 4));
         step();
      end
      wr_valid = 1'b0;
      repeat (2) step();
      pix_stb = 1'b0; active = 1'b0;
      repeat (10) step();
      check_eq("full_drained", 32'(n_wr_seen - seen0), 32'(4));

      // Out-of-range write is swallowed, a following write still lands
      seen0 = n_wr_seen;
      wr_valid = 1'b1; wr_addr = AW'(FB); wr_data = 8'h77;
      check_eq("oor_ready", 32'(wr_ready), 32'(1));
      step();
      wr_addr = AW'(17'h00020); wr_data = 8'h11;
      check_eq("oor_next_ready", 32'(wr_ready), 32'(1));
      step();
      wr_valid = 1'b0;
      repeat (6) step();
      check_eq("oor_writes", 32'(n_wr_seen - seen0), 32'(1));

      // Clear with two pending writes, second one in the request cycle
      done0 = n_done;
      pix_stb = 1'b1; active = 1'b1; xy = AW'(17'h00400);
      wr_valid = 1'b1; wr_addr = AW'(17'h00040); wr_data = 8'hAA;
      step();
      wr_addr = AW'(17'h00041); wr_data = 8'hBB;
      clear_req = 1'b1; clear_colour = 8'h00;
      check_eq("clr_req_ready", 32'(wr_ready), 32'(1));
      step();
      wr_valid = 1'b0; clear_req = 1'b0;
      for (int a = 0; a < int'(FB); a++) wr_q.push_back({AW'(a), 8'h00});
      for (int i = 0; i < 4; i++) begin
         check_eq("drain_busy", 32'(clear_busy), 32'(1));
         check_eq("drain_ready", 32'(wr_ready), 32'(0));
         step();
      end
      pix_stb = 1'b0; active = 1'b0;
      for (int i = 0; i < 80000 && !clear_done; i++) begin
         check_eq("clr_ready", 32'(wr_ready), 32'(0));
         step();
      end
      check_eq("clr_finished", 32'(clear_done), 32'(1));
      repeat (3) step();
      check_eq("clr_done_pulses", 32'(n_done - done0), 32'(1));
      check_eq("clr_all_written", 32'(wr_q.size()), 32'(0));
      check_eq("clr_idle_busy", 32'(clear_busy), 32'(0));
      check_eq("clr_idle_ready", 32'(wr_ready), 32'(1));

      // Reset in the middle of a clear
      track_wr = 1'b0;
      n_clr_we = 0;
      done0 = n_done;
      clear_req = 1'b1; clear_colour = 8'h5A;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 3000 && n_clr_we < 1000; i++) step();
      check_eq("mid_clr_progress", 32'(n_clr_we >= 1000), 32'(1));
      check_eq("mid_clr_busy", 32'(clear_busy), 32'(1));
      rst = 1'b1;
      step();
      check_eq("mid_rst_we", 32'(ram_we), 32'(0));
      check_eq("mid_rst_addr", 32'(ram_addr), 32'(0));
      check_eq("mid_rst_wdata", 32'(ram_wdata), 32'(0));
      check_eq("mid_rst_busy", 32'(clear_busy), 32'(0));
      check_eq("mid_rst_done", 32'(clear_done), 32'(0));
      check_eq("mid_rst_pix", 32'({pix_valid, pix_data}), 32'(0));
      rst = 1'b0;
      we0 = n_clr_we;
      repeat (6) step();
      check_eq("mid_no_done", 32'(n_done - done0), 32'(0));
      check_eq("mid_no_writes", 32'(n_clr_we - we0), 32'(0));
      check_eq("mid_ready", 32'(wr_ready), 32'(1));
      track_wr = 1'b1;

      check_eq("rd_queue_empty", 32'(rd_q.size()), 32'(0));
      check_eq("wr_queue_empty", 32'(wr_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
